// File: rtl/dc_frame_line_scheduler_pkg.sv
// Shared types and default widths for the frame/line scheduler.
package dc_sched_pkg;

  localparam int SCR_SIZE_WIDTH_DEF     = 12;
  localparam int TEX_SIZE_WIDTH_DEF     = 12;
  localparam int LINE_NUMBER_WIDTH_DEF  = 12;
  localparam int UNDERRUN_CNT_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    WAIT_FRAME,
    ISSUE_CTL,
    RUN_LINE,
    FRAME_DONE
  } sched_state_e;

endpackage

// File: rtl/dc_frame_line_scheduler_if.sv
// IPU control, texture-request and line-fetch handshakes around the scheduler.
interface dc_frame_line_scheduler_if
  import dc_sched_pkg::*;
#(
  parameter int SCR_W = SCR_SIZE_WIDTH_DEF,
  parameter int TEX_W = TEX_SIZE_WIDTH_DEF,
  parameter int LN_W  = LINE_NUMBER_WIDTH_DEF
) ();

  logic             ctl_valid;
  logic             ctl_ready;
  logic [SCR_W-1:0] ctl_screen_y;
  logic             status_done;
  logic             tex_request_valid;
  logic             tex_request_ready;
  logic [TEX_W-1:0] tex_request_y;
  logic             line_data_valid;
  logic             line_data_ready;
  logic [LN_W-1:0]  line_number;

  modport master (
    output ctl_valid, ctl_screen_y, tex_request_ready, line_data_valid, line_number,
    input  ctl_ready, status_done, tex_request_valid, tex_request_y, line_data_ready
  );

  modport slave (
    input  ctl_valid, ctl_screen_y, tex_request_ready, line_data_valid, line_number,
    output ctl_ready, status_done, tex_request_valid, tex_request_y, line_data_ready
  );

endinterface

// File: rtl/dc_frame_line_scheduler_req_bridge.sv
// One-entry valid/ready register; the held entry always drains, new entries
// are taken only while accept_en_i is set.
module dc_req_bridge #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 12
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en_i,
  input  logic             accept_en_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [IN_W-1:0]  in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [OUT_W-1:0] out_data_o
);

  logic             valid_q;
  logic [OUT_W-1:0] data_q;

  assign in_ready_o  = accept_en_i & ~valid_q;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (en_i) begin
      if (in_valid_i && in_ready_o) begin
        valid_q <= 1'b1;
        data_q  <= OUT_W'(in_data_i);
      end else if (out_ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dc_frame_line_scheduler.sv
// Walks the IPU through one output frame line by line, bridging texture-line
// requests to the fetch unit and tracking frame completion and underruns.
//
//   state      | meaning
//   WAIT_FRAME | idle, waiting for vertical-blanking falling edge
//   ISSUE_CTL  | presenting ctl for line y to the IPU
//   RUN_LINE   | IPU working on line y, waiting for status_done
//   FRAME_DONE | frame_finished pulse cycle
module dc_frame_line_scheduler
  import dc_sched_pkg::*;
#(
  parameter int SCR_SIZE_WIDTH     = SCR_SIZE_WIDTH_DEF,
  parameter int TEX_SIZE_WIDTH     = TEX_SIZE_WIDTH_DEF,
  parameter int LINE_NUMBER_WIDTH  = LINE_NUMBER_WIDTH_DEF,
  parameter int UNDERRUN_CNT_WIDTH = UNDERRUN_CNT_WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          en_i,
  input  logic                          vertical_blanking_i,
  input  logic [SCR_SIZE_WIDTH-1:0]     cfg_screen_height_i,
  dc_frame_line_scheduler_if.master     bus,
  output logic                          frame_finished_o,
  output logic                          frame_underrun_o,
  output logic [UNDERRUN_CNT_WIDTH-1:0] underrun_count_o
);

  sched_state_e                  state_q;
  logic [SCR_SIZE_WIDTH-1:0]     y_q;
  logic [SCR_SIZE_WIDTH-1:0]     h_q;
  logic                          vblank_prev_q;
  logic                          ctl_valid_q;
  logic                          frame_finished_q;
  logic                          frame_underrun_q;
  logic [UNDERRUN_CNT_WIDTH-1:0] underrun_cnt_q;

  logic frame_start;
  logic vblank_rise;
  logic last_line;
  logic cnt_sat;

  assign frame_start = vblank_prev_q & ~vertical_blanking_i;
  assign vblank_rise = ~vblank_prev_q & vertical_blanking_i;
  assign last_line   = (y_q == h_q - SCR_SIZE_WIDTH'(1));
  assign cnt_sat     = &underrun_cnt_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q          <= WAIT_FRAME;
      y_q              <= '0;
      h_q              <= '0;
      vblank_prev_q    <= 1'b1;
      ctl_valid_q      <= 1'b0;
      frame_finished_q <= 1'b0;
      frame_underrun_q <= 1'b0;
      underrun_cnt_q   <= '0;
    end else if (en_i) begin
      vblank_prev_q    <= vertical_blanking_i;
      frame_finished_q <= 1'b0;
      case (state_q)
        WAIT_FRAME: begin
          if (frame_start) begin
            h_q              <= cfg_screen_height_i;
            y_q              <= '0;
            frame_underrun_q <= 1'b0;
            if (cfg_screen_height_i == '0) begin
              frame_finished_q <= 1'b1;
            end else begin
              ctl_valid_q <= 1'b1;
              state_q     <= ISSUE_CTL;
            end
          end
        end
        ISSUE_CTL: begin
          if (vblank_rise) begin
            frame_underrun_q <= 1'b1;
            if (!cnt_sat) underrun_cnt_q <= underrun_cnt_q + 1'b1;
            ctl_valid_q <= 1'b0;
            state_q     <= WAIT_FRAME;
          end else if (bus.ctl_ready) begin
            ctl_valid_q <= 1'b0;
            state_q     <= RUN_LINE;
          end
        end
        RUN_LINE: begin
          // Finishing the last line beats a coincident vblank rise.
          if (bus.status_done && last_line) begin
            frame_finished_q <= 1'b1;
            state_q          <= FRAME_DONE;
          end else if (vblank_rise) begin
            frame_underrun_q <= 1'b1;
            if (!cnt_sat) underrun_cnt_q <= underrun_cnt_q + 1'b1;
            state_q <= WAIT_FRAME;
          end else if (bus.status_done) begin
            y_q         <= y_q + SCR_SIZE_WIDTH'(1);
            ctl_valid_q <= 1'b1;
            state_q     <= ISSUE_CTL;
          end
        end
        FRAME_DONE: state_q <= WAIT_FRAME;
        default:    state_q <= WAIT_FRAME;
      endcase
    end
  end

  dc_req_bridge #(
    .IN_W  (TEX_SIZE_WIDTH),
    .OUT_W (LINE_NUMBER_WIDTH)
  ) u_req_bridge (
    .clk         (clk),
    .nrst        (nrst),
    .en_i        (en_i),
    .accept_en_i (state_q != WAIT_FRAME),
    .in_valid_i  (bus.tex_request_valid),
    .in_ready_o  (bus.tex_request_ready),
    .in_data_i   (bus.tex_request_y),
    .out_valid_o (bus.line_data_valid),
    .out_ready_i (bus.line_data_ready),
    .out_data_o  (bus.line_number)
  );

  assign bus.ctl_valid    = ctl_valid_q;
  assign bus.ctl_screen_y = y_q;
  assign frame_finished_o = frame_finished_q;
  assign frame_underrun_o = frame_underrun_q;
  assign underrun_count_o = underrun_cnt_q;

endmodule

// File: tb/tb_dc_frame_line_scheduler.sv
// Directed and randomized frames checked against a line/request-order model.
module tb_dc_frame_line_scheduler;
  import dc_sched_pkg::*;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        en = 1'b1;
  logic        vb = 1'b1;
  logic [11:0] cfg = '0;
  logic        ff;
  logic        fu;
  logic [7:0]  ucnt;

  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;

  dc_frame_line_scheduler_if bus ();

  dc_frame_line_scheduler dut (
    .clk                 (clk),
    .nrst                (nrst),
    .en_i                (en),
    .vertical_blanking_i (vb),
    .cfg_screen_height_i (cfg),
    .bus                 (bus),
    .frame_finished_o    (ff),
    .frame_underrun_o    (fu),
    .underrun_count_o    (ucnt)
  );

  always #5 clk = ~clk;

  // fetch side: 0 = always ready, 1 = random ready, 2 = driven by the sequence
  int          fetch_mode = 0;
  logic        ldr_auto = 1'b1;
  logic        ldr_man = 1'b0;
  int          ff_seen = 0;
  logic [11:0] got_ln[$];
  logic [11:0] exp_ln[$];
  logic [11:0] got_y[$];

  assign bus.line_data_ready = (fetch_mode == 2) ? ldr_man : ldr_auto;

  always @(negedge clk) begin
    logic r;
    r = (fetch_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    ldr_auto = r;
    if (ff === 1'b1) ff_seen++;
    if (fetch_mode != 2 && nrst && en && bus.line_data_valid && r)
      got_ln.push_back(bus.line_number);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_frame(input int h);
    cfg = 12'(h);
    vb = 1'b1;
    step();
    step();
    vb = 1'b0;
    step();
  endtask

  task automatic do_line(input int stall, input int nreq, input int dly, input bit finish);
    int n;
    logic [11:0] yv;
    logic [11:0] ty;
    n = 0;
    while (bus.ctl_valid !== 1'b1 && n < 50) begin step(); n++; end
    chk("ctl_valid_wait", 32'(bus.ctl_valid), 1);
    yv = bus.ctl_screen_y;
    got_y.push_back(yv);
    bus.ctl_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      step();
      chk("ctl_hold_valid", 32'(bus.ctl_valid), 1);
      chk("ctl_hold_y", 32'(bus.ctl_screen_y), 32'(yv));
    end
    bus.ctl_ready = 1'b1;
    step();
    bus.ctl_ready = 1'b0;
    chk("ctl_accept", 32'(bus.ctl_valid), 0);
    for (int r = 0; r < nreq; r++) begin
      ty = 12'($urandom_range(0, 4095));
      bus.tex_request_y = ty;
      bus.tex_request_valid = 1'b1;
      n = 0;
      while (bus.tex_request_ready !== 1'b1 && n < 50) begin step(); n++; end
      chk("tex_ready_wait", 32'(bus.tex_request_ready), 1);
      exp_ln.push_back(ty);
      step();
      bus.tex_request_valid = 1'b0;
    end
    if (finish) begin
      repeat (dly) step();
      bus.status_done = 1'b1;
      step();
      bus.status_done = 1'b0;
    end
  endtask

  task automatic end_frame(input int h, input int base);
    int n;
    n = 0;
    step();
    step();
    while (bus.line_data_valid && n < 100) begin step(); n++; end
    chk("drain", 32'(bus.line_data_valid), 0);
    chk("frame_lines", 32'(got_y.size()), 32'(h));
    foreach (got_y[i]) chk("frame_y_seq", 32'(got_y[i]), 32'(i));
    chk("frame_finished_count", 32'(ff_seen - base), 1);
    chk("frame_underrun_clear", 32'(fu), 0);
  endtask

  task automatic run_frame(input int h, input bit rnd, input int stall, input int nreq, input int dly);
    int base;
    got_y.delete();
    base = ff_seen;
    start_frame(h);
    for (int l = 0; l < h; l++) begin
      if (rnd) do_line($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4), 1'b1);
      else     do_line(stall, nreq, dly, 1'b1);
    end
    end_frame(h, base);
  endtask

  initial begin
    int base;
    bus.ctl_ready = 1'b0;
    bus.status_done = 1'b0;
    bus.tex_request_valid = 1'b0;
    bus.tex_request_y = '0;

    #1;
    chk("rst_ctl_valid", 32'(bus.ctl_valid), 0);
    chk("rst_ctl_y", 32'(bus.ctl_screen_y), 0);
    chk("rst_tex_ready", 32'(bus.tex_request_ready), 0);
    chk("rst_ldv", 32'(bus.line_data_valid), 0);
    chk("rst_flags", 32'({ff, fu, ucnt}), 0);
    @(negedge clk);
    nrst = 1'b1;
    step();

    // H=3, no stalls, done 5 cycles after accept
    run_frame(3, 1'b0, 0, 0, 5);
    // ctl_ready held off for 4 cycles on every line
    run_frame(2, 1'b0, 4, 1, 3);

    // randomized frames against the line/request-order model
    fetch_mode = 1;
    for (int f = 0; f < 6; f++) begin
      got_ln.delete();
      exp_ln.delete();
      run_frame($urandom_range(1, 5), 1'b1, 0, 0, 0);
      chk("fetch_count", 32'(got_ln.size()), 32'(exp_ln.size()));
      foreach (exp_ln[i])
        if (i < got_ln.size()) chk("fetch_line", 32'(got_ln[i]), 32'(exp_ln[i]));
    end
    fetch_mode = 0;

    // directed bridging with fetch back-pressure
    got_y.delete();
    base = ff_seen;
    start_frame(1);
    do_line(0, 0, 0, 1'b0);
    fetch_mode = 2;
    ldr_man = 1'b0;
    bus.tex_request_y = 12'd7;
    bus.tex_request_valid = 1'b1;
    chk("br_ready_idle", 32'(bus.tex_request_ready), 1);
    step();
    bus.tex_request_y = 12'd8;
    for (int i = 0; i < 3; i++) begin
      chk("br_hold_valid", 32'(bus.line_data_valid), 1);
      chk("br_hold_line", 32'(bus.line_number), 7);
      chk("br_busy", 32'(bus.tex_request_ready), 0);
      step();
    end
    ldr_man = 1'b1;
    step();
    ldr_man = 1'b0;
    chk("br_drained", 32'(bus.line_data_valid), 0);
    chk("br_ready_again", 32'(bus.tex_request_ready), 1);
    step();
    bus.tex_request_valid = 1'b0;
    chk("br_second_valid", 32'(bus.line_data_valid), 1);
    chk("br_second_line", 32'(bus.line_number), 8);
    ldr_man = 1'b1;
    step();
    chk("br_second_drain", 32'(bus.line_data_valid), 0);
    fetch_mode = 0;
    bus.status_done = 1'b1;
    step();
    bus.status_done = 1'b0;
    end_frame(1, base);

    // en low during ISSUE_CTL: ready and a vblank pulse must be ignored
    got_y.delete();
    base = ff_seen;
    start_frame(2);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) vb = 1'b1;
      if (i == 5) bus.ctl_ready = 1'b1;
      if (i == 7) vb = 1'b0;
      step();
      chk("en_hold", 32'({bus.ctl_valid, bus.ctl_screen_y, fu}), 32'({1'b1, 12'd0, 1'b0}));
    end
    bus.ctl_ready = 1'b0;
    en = 1'b1;
    step();
    chk("en_resume_valid", 32'(bus.ctl_valid), 1);
    chk("en_resume_underrun", 32'(ucnt), 32'(exp_cnt));
    do_line(1, 1, 2, 1'b1);
    do_line(0, 1, 2, 1'b1);
    end_frame(2, base);

    // underrun during line 2 of H=4, then clean restart
    got_y.delete();
    start_frame(4);
    do_line(0, 0, 2, 1'b1);
    do_line(0, 0, 2, 1'b1);
    do_line(0, 1, 0, 1'b0);
    vb = 1'b1;
    step();
    exp_cnt++;
    chk("ur_flag", 32'(fu), 1);
    chk("ur_count", 32'(ucnt), 32'(exp_cnt));
    chk("ur_ctl_idle", 32'(bus.ctl_valid), 0);
    chk("ur_tex_ready", 32'(bus.tex_request_ready), 0);
    vb = 1'b0;
    step();
    chk("ur_restart_flag", 32'(fu), 0);
    chk("ur_restart_valid", 32'(bus.ctl_valid), 1);
    chk("ur_restart_y", 32'(bus.ctl_screen_y), 0);
    got_y.delete();
    base = ff_seen;
    for (int l = 0; l < 4; l++) do_line(0, 1, 1, 1'b1);
    end_frame(4, base);

    // done and vblank rise together on the last line
    got_y.delete();
    start_frame(1);
    do_line(0, 0, 0, 1'b0);
    bus.status_done = 1'b1;
    vb = 1'b1;
    step();
    bus.status_done = 1'b0;
    chk("sim_finished", 32'(ff), 1);
    chk("sim_no_underrun", 32'(fu), 0);
    chk("sim_count", 32'(ucnt), 32'(exp_cnt));
    step();
    chk("sim_pulse_end", 32'(ff), 0);

    // zero-height frame
    start_frame(0);
    chk("h0_finished", 32'(ff), 1);
    chk("h0_no_ctl", 32'(bus.ctl_valid), 0);
    step();
    chk("h0_pulse_end", 32'(ff), 0);
    chk("h0_still_idle", 32'(bus.ctl_valid), 0);

    // drive the counter to saturation, then one more
    while (exp_cnt < 255) begin
      start_frame(1);
      vb = 1'b1;
      step();
      exp_cnt++;
    end
    chk("sat_reach", 32'(ucnt), 32'(exp_cnt));
    start_frame(1);
    vb = 1'b1;
    step();
    exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
    chk("sat_hold", 32'(ucnt), 32'(exp_cnt));
    chk("sat_flag", 32'(fu), 1);

    // async reset while RUN_LINE with a pending fetch
    start_frame(1);
    do_line(0, 0, 0, 1'b0);
    fetch_mode = 2;
    ldr_man = 1'b0;
    bus.tex_request_y = 12'd5;
    bus.tex_request_valid = 1'b1;
    step();
    bus.tex_request_valid = 1'b0;
    chk("pre_rst_ldv", 32'(bus.line_data_valid), 1);
    #2 nrst = 1'b0;
    #1;
    chk("mid_rst_ctl", 32'({bus.ctl_valid, bus.ctl_screen_y}), 0);
    chk("mid_rst_bridge", 32'({bus.tex_request_ready, bus.line_data_valid, bus.line_number}), 0);
    chk("mid_rst_flags", 32'({ff, fu, ucnt}), 0);
    vb = 1'b1;
    fetch_mode = 0;
    exp_cnt = 0;
    @(negedge clk);
    nrst = 1'b1;
    step();
    run_frame(2, 1'b0, 1, 1, 1);
    chk("post_rst_count", 32'(ucnt), 32'(exp_cnt));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dc_frame_line_scheduler.md
Name: dc_frame_line_scheduler

Overview:
- Sequences the image processing unit (IPU) through one output frame, line by line.
- Starts a frame on the video unit's vertical-blanking falling edge.
- Per line: issues the IPU control transaction, bridges the IPU's texture-line requests to the fetch interface, and waits for the line-done status.
- Reports frame completion, and flags an underrun when the next vertical blanking arrives before the frame is done. Sits between the IPU, the fetching/buffering path and the video unit.

Parameters:
- SCR_SIZE_WIDTH, 12, width of screen coordinates and screen height
- TEX_SIZE_WIDTH, 12, width of the texture line index
- LINE_NUMBER_WIDTH, 12, width of line_number toward the fetch unit; must be >= TEX_SIZE_WIDTH
- UNDERRUN_CNT_WIDTH, 8, width of the saturating underrun counter

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- en  in  1  global enable; when 0, all state is held
- vertical_blanking  in  1  video-unit vertical blanking level
- cfg_screen_height  in  SCR_SIZE_WIDTH  output lines per frame; latched at frame start
- ctl_valid  out  1  IPU control request
- ctl_ready  in  1  IPU accepts control
- ctl_screen_y  out  SCR_SIZE_WIDTH  screen line being issued
- status_done  in  1  IPU single-cycle pulse: current line finished
- tex_request_valid  in  1  IPU texture line request
- tex_request_ready  out  1  request accepted
- tex_request_y  in  TEX_SIZE_WIDTH  requested texture line
- line_data_valid  out  1  fetch request valid
- line_data_ready  in  1  fetch unit accepts
- line_number  out  LINE_NUMBER_WIDTH  line to fetch (zero-extended tex_request_y)
- frame_finished  out  1  one-cycle pulse: last line done
- frame_underrun  out  1  sticky underrun flag for the current frame
- underrun_count  out  UNDERRUN_CNT_WIDTH  saturating count of underrun events

Behaviour:
- Reset, async on nrst low: state WAIT_FRAME, y=0, vblank_d=1, all outputs 0.
- en=0: no register updates at all, including vblank_d. Outputs are held. Handshakes do not complete, because no state advances.
- Frame start (fs) = vblank_d & ~vertical_blanking, evaluated in WAIT_FRAME only. vblank_d is vertical_blanking registered each enabled cycle.
- On fs:
  - Latch H = cfg_screen_height, set y=0, clear frame_underrun.
  - If H==0: pulse frame_finished the next cycle and stay in WAIT_FRAME. No ctl is issued.
  - Otherwise go to ISSUE_CTL. ctl_valid is high the cycle after fs.
- ISSUE_CTL: ctl_valid=1, ctl_screen_y=y. When ctl_valid & ctl_ready, go to RUN_LINE. ctl_valid and ctl_screen_y stay stable until accepted.
- RUN_LINE, request bridging:
  - tex_request_ready = ~line_data_valid.
  - On tex_request_valid & tex_request_ready: line_number <= tex_request_y and line_data_valid <= 1 the next cycle (1-cycle latency).
  - line_data_valid clears on line_data_ready. It is held stable until then.
- RUN_LINE, line completion on status_done:
  - If y==H-1: go to FRAME_DONE.
  - Otherwise y <= y+1 and go to ISSUE_CTL.
- status_done is ignored outside RUN_LINE. The bridge runs in any state except WAIT_FRAME. A pending line_data_valid completes normally across state changes.
- FRAME_DONE: frame_finished=1 for exactly one cycle, then WAIT_FRAME.
- Underrun:
  - Trigger: a vertical_blanking rising edge (~vblank_d & vertical_blanking) while in ISSUE_CTL or RUN_LINE.
  - Action: set frame_underrun, increment underrun_count (saturating at all-ones), abort to WAIT_FRAME.
  - A pending line_data_valid still completes its handshake. tex_request_ready=0 in WAIT_FRAME.
- In WAIT_FRAME, a vblank falling edge arriving while a previous abort is pending is treated as a normal fs.
- Simultaneous status_done and vblank rise on the last line: completion wins; frame_finished pulses and there is no underrun.
- y is compared to H-1 at SCR_SIZE_WIDTH bits. H is never 0 in this compare because of the H==0 bypass.

Decomposition:
- Package dc_sched_pkg holds:
  - state enum: WAIT_FRAME, ISSUE_CTL, RUN_LINE, FRAME_DONE
  - default width constants
- Sub-module dc_req_bridge: one-entry valid/ready register for the tex_request→line_data path, reusable by the buffering path.
- FSM and counters live in the top.

Test Plan:
- H=3, ctl_ready and line_data_ready tied 1, status_done 5 cycles after each ctl accept:
  - ctl_screen_y sequence 0,1,2.
  - Exactly one frame_finished pulse.
  - frame_underrun=0.
- ctl_ready low 4 cycles → ctl_valid held and ctl_screen_y stable for all 4 cycles; accept on the 5th.
- Request bridging:
  - tex_request_y=7 accepted, line_data_ready held low 3 cycles → line_number=7 held; tex_request_ready=0 until drained.
  - A second request, y=8, is accepted the cycle after the drain.
- H=4, vertical_blanking rises during line 2:
  - Abort to WAIT_FRAME, frame_underrun=1, underrun_count=1.
  - On the next fs, frame_underrun clears and ctl_screen_y=0.
- Boundary cases:
  - H=0 → frame_finished pulses one cycle after fs, no ctl_valid.
  - underrun_count at 255 plus another underrun → stays 255.
- Mid-operation:
  - nrst asserted in RUN_LINE → all outputs 0 immediately.
  - en=0 for 10 cycles during ISSUE_CTL → no state change; resumes identically afterwards.
